// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - program counter owner and instruction fetch sequencer
module pc_fetch_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] INC_STEP     = 16'h0001
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_addr,
  input  logic        halt,
  output logic        halted
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;

  state_t      state;
  logic [15:0] pc;

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= 16'h0000;
      instr_pc    <= 16'h0000;
      halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) pc <= redirect_addr;
          if (halt) begin
            state  <= HALTED;
            halted <= 1'b1;
          end else begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end
        end

        FETCH: begin
          // A redirect wins over a coincident ack; the returned word is dropped.
          if (redirect_valid) begin
            pc <= redirect_addr;
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= pc;
            pc          <= pc + INC_STEP;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end

        HOLD: begin
          // Accept delivers the word; redirect without accept squashes it. Both leave HOLD.
          if (instr_ready || redirect_valid) begin
            instr_valid <= 1'b0;
            if (redirect_valid) pc <= redirect_addr;
            if (halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state    <= FETCH;
              imem_req <= 1'b1;
            end
          end
        end

        HALTED: begin
          if (redirect_valid) pc <= redirect_addr;
          if (!halt) begin
            state    <= FETCH;
            halted   <= 1'b0;
            imem_req <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
